// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - iterative EX-stage multiply/divide unit with HI/LO registers
// Divider is built only when EX_MDU_DIV_EN is defined; otherwise DIV/DIVU behave as NONE.
module ex_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_valid,
    input  logic [2:0]       md_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef EX_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               neg_q;
`ifdef EX_MDU_DIV_EN
    logic               div_q, dz_q, rneg_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
`endif

    logic               is_mul_op, is_div_op, signed_op, start;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign is_mul_op = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_div_op = DIV_EN && ((md_op == OP_DIV) || (md_op == OP_DIVU));
    assign signed_op = (md_op == OP_MULT) || (md_op == OP_DIV);
    assign start     = (state_q == S_IDLE) && md_valid && (is_mul_op || is_div_op);

    assign busy  = (state_q == S_MUL) || (state_q == S_DIV);
    assign stall = busy || start;
    assign done  = (state_q == S_DONE) && !flush;
    assign hi    = hi_q;
    assign lo    = lo_q;

    assign a_neg = signed_op && src_a[WIDTH-1];
    assign b_neg = signed_op && src_b[WIDTH-1];
    assign mag_a = a_neg ? -src_a : src_a;
    assign mag_b = b_neg ? -src_b : src_b;

    // acc holds {partial product, remaining multiplier bits}; shifts right each step
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef EX_MDU_DIV_EN
    // acc holds {partial remainder, dividend/quotient bits}; shifts left each step
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef EX_MDU_DIV_EN
        if (div_q) begin
            if (dz_q) begin
                res_hi = a_raw_q;
                res_lo = '1;
            end else begin
                res_lo = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                res_hi = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q   <= {{WIDTH{1'b0}}, (is_mul_op ? mag_b : mag_a)};
                        opnd_q  <= is_mul_op ? mag_a : mag_b;
                        neg_q   <= a_neg ^ b_neg;
                        cnt_q   <= '0;
                        state_q <= is_mul_op ? S_MUL : S_DIV;
`ifdef EX_MDU_DIV_EN
                        div_q   <= !is_mul_op;
                        dz_q    <= (src_b == '0);
                        rneg_q  <= a_neg;
                        a_raw_q <= src_a;
`endif
                    end else if (md_valid && md_op == OP_MTHI) begin
                        hi_q <= src_a;
                    end else if (md_valid && md_op == OP_MTLO) begin
                        lo_q <= src_a;
                    end
                end
                S_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) state_q <= S_DONE;
                end
`ifdef EX_MDU_DIV_EN
                S_DIV: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) state_q <= S_DONE;
                end
`endif
                S_DONE: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - randomized self-checking bench for ex_mdu against an arithmetic model
module tb_ex_mdu;
    localparam int W = 32;
    localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                           OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6, OP_RSVD = 3'd7;

    logic         clk = 1'b0;
    logic         rst, md_valid, flush;
    logic [2:0]   md_op;
    logic [W-1:0] src_a, src_b;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;
    logic [W-1:0] m_hi, m_lo;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mdu #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .md_valid(md_valid), .md_op(md_op), .flush(flush),
        .src_a(src_a), .src_b(src_b), .busy(busy), .stall(stall), .done(done),
        .hi(hi), .lo(lo)
    );

    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                  output logic [W-1:0] ehi, elo);
        longint sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ehi = m_hi;
        elo = m_lo;
        case (op)
            OP_MULT:  begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; ehi = p[63:32]; elo = p[31:0]; end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    ehi = a;
                    elo = '1;
                end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    ehi = '0;
                    elo = 32'h8000_0000;
                end else if (op == OP_DIV) begin
                    q = sa / sb; r = sa % sb;
                    ehi = r[31:0]; elo = q[31:0];
                end else begin
                    ehi = a % b; elo = a / b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic run_muldiv(input logic [2:0] op, input logic [W-1:0] a, b, input bit hold);
        logic [W-1:0] ehi, elo;
        int done_at, n_done, stall_bad, busy_bad, early;
        done_at = -1; n_done = 0; stall_bad = 0; busy_bad = 0; early = 0;
        model(op, a, b, ehi, elo);
        @(negedge clk);
        md_valid = 1'b1; md_op = op; src_a = a; src_b = b;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL accept_stall op=%0d: got %b need 1", op, stall); end
        @(posedge clk);
        #1;
        if (!hold) md_valid = 1'b0;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin n_done++; done_at = k; end
            if (stall !== 1'(k <= W)) stall_bad++;
            if (busy !== 1'(k <= W)) busy_bad++;
            if (k == W + 1 && (hi !== m_hi || lo !== m_lo)) early++;
            if (hold) begin
                if (k <= W) begin src_a = $urandom; src_b = $urandom; end
                else md_valid = 1'b0;
            end
        end
        m_hi = ehi; m_lo = elo;
        checks++;
        if (n_done != 1 || done_at != W + 1) begin
            errors++; $display("FAIL done_timing op=%0d: pulses=%0d at cycle %0d need 1 at %0d", op, n_done, done_at, W + 1);
        end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL stall_window op=%0d: %0d bad cycles need 0", op, stall_bad); end
        checks++;
        if (busy_bad != 0) begin errors++; $display("FAIL busy_window op=%0d: %0d bad cycles need 0", op, busy_bad); end
        checks++;
        if (early != 0) begin errors++; $display("FAIL hilo_early op=%0d: hi/lo changed before DONE edge", op); end
        checks++;
        if (hi !== m_hi) begin errors++; $display("FAIL result_hi op=%0d a=%h b=%h: got %h need %h", op, a, b, hi, m_hi); end
        checks++;
        if (lo !== m_lo) begin errors++; $display("FAIL result_lo op=%0d a=%h b=%h: got %h need %h", op, a, b, lo, m_lo); end
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || stall !== 1'b0 || busy !== 1'b0 || hi !== m_hi || lo !== m_lo) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s: %0d cycles with activity or hi/lo=%h/%h need %h/%h", name, bad, hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_reset();
        rst = 1'b1; md_valid = 1'b0; md_op = OP_NONE; flush = 1'b0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, stall, done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b need 000", {busy, stall, done}); end
        checks++;
        if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL reset_hilo: got %h/%h need 0/0", hi, lo); end
        rst = 1'b0; m_hi = '0; m_lo = '0;
    endtask

    task automatic test_move();
        logic [W-1:0] v;
        int bad;
        bad = 0;
        @(negedge clk);
        md_valid = 1'b1; md_op = OP_MTHI; src_a = 32'h1234_5678;
        #1; if (stall !== 1'b0) bad++;
        @(negedge clk);
        m_hi = 32'h1234_5678;
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL mthi: got %h/%h need %h/%h", hi, lo, m_hi, m_lo); end
        if (done !== 1'b0) bad++;
        md_op = OP_MTLO; src_a = 32'h9ABC_DEF0;
        #1; if (stall !== 1'b0) bad++;
        @(negedge clk);
        m_lo = 32'h9ABC_DEF0;
        md_valid = 1'b0;
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL mtlo: got %h/%h need %h/%h", hi, lo, m_hi, m_lo); end
        if (done !== 1'b0) bad++;
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            md_valid = 1'b1; md_op = (i % 2 == 0) ? OP_MTLO : OP_MTHI; src_a = v;
            #1; if (stall !== 1'b0) bad++;
            @(negedge clk);
            if (i % 2 == 0) m_lo = v; else m_hi = v;
            if (done !== 1'b0) bad++;
            checks++;
            if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL move_rand %0d: got %h/%h need %h/%h", i, hi, lo, m_hi, m_lo); end
        end
        md_valid = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL move_ctrl: %0d stall/done events need 0", bad); end
    endtask

    task automatic test_none_ops();
        @(negedge clk);
        md_valid = 1'b1; md_op = OP_NONE; src_a = $urandom;
        watch_quiet("op_none", 3);
        md_op = OP_RSVD;
        watch_quiet("op_reserved", 3);
`ifndef EX_MDU_DIV_EN
        md_op = OP_DIV; src_a = 32'h0000_0008; src_b = 32'h0000_0002;
        watch_quiet("div_disabled", 4);
        md_op = OP_DIVU;
        watch_quiet("divu_disabled", 4);
`endif
        md_valid = 1'b0;
    endtask

    task automatic test_flush();
        @(negedge clk);
        md_valid = 1'b1; md_op = OP_MULT; src_a = $urandom; src_b = $urandom;
        @(posedge clk);
        #1 md_valid = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_idle: busy=%b stall=%b need 0 0", busy, stall); end
        watch_quiet("flush_quiet", W + 4);
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        md_valid = 1'b1; src_a = $urandom; src_b = $urandom | 1;
`ifdef EX_MDU_DIV_EN
        md_op = OP_DIV;
`else
        md_op = OP_MULT;
`endif
        @(posedge clk);
        #1 md_valid = 1'b0;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        rst = 1'b1; flush = 1'b1; md_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; md_valid = 1'b0;
        m_hi = '0; m_lo = '0;
        checks++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid: hi=%h lo=%h busy=%b need 0 0 0", hi, lo, busy); end
        watch_quiet("rst_quiet", W + 4);
    endtask

    task automatic test_random(input int n);
        logic [2:0] op;
        logic [W-1:0] a, b;
        for (int i = 0; i < n; i++) begin
`ifdef EX_MDU_DIV_EN
            op = 3'($urandom_range(1, 4));
`else
            op = 3'($urandom_range(1, 2));
`endif
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 255)) * (($urandom % 2) ? 1 : -1);
                default: ;
            endcase
            run_muldiv(op, a, b, 1'($urandom % 2));
        end
    endtask

    initial begin
        test_reset();
        run_muldiv(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        run_muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
`ifdef EX_MDU_DIV_EN
        run_muldiv(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_muldiv(OP_DIVU, 32'h0000_0009, 32'h0000_0000, 1'b0);
        run_muldiv(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
`endif
        test_move();
        test_none_ops();
        test_flush();
        test_rst_mid();
        test_random(16);
        run_muldiv(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width in bits (even, >= 8).
REQ-002 Parameter CNT_W, default 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.
REQ-003 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 md_valid  in  1  EX stage presents a mul/div/move operation this cycle.
REQ-007 md_op  in  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NONE).
REQ-008 flush  in  1  pipeline flush; aborts any operation in flight.
REQ-009 src_a  in  WIDTH  forwarded operand A (multiplicand / dividend / move source).
REQ-010 src_b  in  WIDTH  forwarded operand B (multiplier / divisor).
REQ-011 busy  out  1  iterative operation in progress.
REQ-012 stall  out  1  request to hold IF/ID/EX stages.
REQ-013 done  out  1  one-cycle pulse when HI/LO receive a mul/div result.
REQ-014 hi  out  WIDTH  HI register.
REQ-015 lo  out  WIDTH  LO register.

Function
REQ-016 States: IDLE, MUL, DIV, DONE; reserved encodings return to IDLE.
REQ-017 IDLE, md_valid, op MULT/MULTU/DIV/DIVU, no flush: latch operand magnitudes and sign flags, counter=0, enter MUL or DIV next edge.
REQ-018 MUL: one shift-add iteration per cycle, 2*WIDTH-bit accumulator.
REQ-019 DIV: one restoring shift-subtract iteration per cycle on magnitudes.
REQ-020 Counter increments each MUL/DIV cycle; at counter==WIDTH-1 next state DONE.
REQ-021 DONE: hi/lo written at the DONE edge, done=1 for the DONE cycle only, then IDLE.
REQ-022 Latency: operation accepted in cycle T, done high in cycle T+WIDTH+1, hi/lo valid from T+WIDTH+2.
REQ-023 stall = busy OR (IDLE AND md_valid AND op in {MULT,MULTU,DIV,DIVU}); stall=0 in DONE.
REQ-024 busy=1 in MUL and DIV only.
REQ-025 MULT/DIV signed: result negated when sign flags differ; remainder takes sign of dividend.
REQ-026 Multiply result: hi = upper WIDTH bits, lo = lower WIDTH bits of full product.
REQ-027 Divide result: lo = quotient, hi = remainder.
REQ-028 Divide by zero: lo = all ones, hi = src_a as latched; still WIDTH+1 cycles.
REQ-029 Signed most-negative / -1: lo = most-negative, hi = 0.
REQ-030 MTHI/MTLO in IDLE with md_valid: hi (resp. lo) = src_a at next edge, no stall, no done.
REQ-031 md_valid while busy is ignored; the pipeline holds the instruction until stall drops.
REQ-032 flush in any state: next state IDLE, counter cleared, hi/lo unchanged, done not asserted; flush with md_valid in IDLE: flush wins.
REQ-033 md_op NONE/reserved: no state change.

Reset
REQ-034 rst at an edge: state IDLE, counter 0, hi=0, lo=0, busy=0, stall=0, done=0.
REQ-035 rst mid-operation discards the operation; rst has priority over flush and md_valid.

Configuration
REQ-036 Macro EX_MDU_DIV_EN defined: DIV/DIVU execute per REQ-019..REQ-029.
REQ-037 EX_MDU_DIV_EN undefined: DIV state and divider logic absent; DIV/DIVU treated as NONE (no stall, hi/lo unchanged, no done).

Verification
REQ-038 WIDTH=32, MULT src_a=0xFFFFFFFF, src_b=0x00000002 -> done at T+33, hi=0xFFFFFFFF, lo=0xFFFFFFFE, stall high T..T+32.
REQ-039 MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-040 DIV src_a=0xFFFFFFF9 (-7), src_b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0x00000009 / 0 -> lo=0xFFFFFFFF, hi=0x00000009.
REQ-041 MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated next edges, stall and done never high.
REQ-042 MULT started, flush asserted at T+10 -> IDLE at T+11, busy low, hi/lo keep prior values, no done; rst at T+5 of DIV -> hi=lo=0, IDLE.
REQ-043 Build without EX_MDU_DIV_EN: DIV 0x00000008/0x00000002 -> stall never high, hi/lo unchanged.
